// File: rtl/ft245_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ft245_pkg
// Description : Shared types and constants for the FT245 FIFO bus controller.
//               FSM state encoding, arbitration grant encoding, counter width
//               and a helper that sizes integer parameters for counter loads.
// Revision    : 1.0 - initial release
// ============================================================================
package ft245_pkg;

   localparam int CNT_W = 4;

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      RD_STROBE = 3'd1,
      WR_SETUP  = 3'd2,
      WR_STROBE = 3'd3,
      HOLD      = 3'd4
   } state_t;

   typedef enum logic {
      GRANT_READ  = 1'b0,
      GRANT_WRITE = 1'b1
   } grant_t;

   // Truncates an integer parameter to the phase-counter width.
   function automatic logic [CNT_W-1:0] cnt_init(input int unsigned n);
      return n[CNT_W-1:0];
   endfunction

endpackage
`default_nettype wire

// File: rtl/ft_sync.sv
`default_nettype none
// ============================================================================
// Module      : ft_sync
// Description : N-stage single-bit synchronizer for an asynchronous, idle-high
//               status line. All stages reset to 1 so the line reads as
//               "inactive" until fresh samples have propagated through.
// Ports       : clk      - system clock
//               rst      - synchronous active-high reset
//               i_async  - asynchronous input
//               o_sync   - input delayed by STAGES flops
// Revision    : 1.0 - initial release
// ============================================================================
module ft_sync #(
   parameter int STAGES = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic i_async,
   output logic o_sync
);

   logic [STAGES-1:0] r_sync;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_sync <= '1;
      end else begin
         r_sync <= {r_sync[STAGES-2:0], i_async};
      end
   end

   assign o_sync = r_sync[STAGES-1];

endmodule
`default_nettype wire

// File: rtl/ft245_bus_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : ft245_bus_ctrl
// Description : Sequencer for an FT245-style asynchronous FIFO bus. Shares the
//               bidirectional data bus between the RX stream (host->FPGA reads)
//               and the TX stream (FPGA->host writes) with round-robin
//               arbitration, generates RD#/WR strobe timing, and presents
//               byte-wide valid/ready streams to the register-side logic.
// Ports       : clk, rst                 - clock, synchronous active-high reset
//               FT_RXFn, FT_TXEn         - async chip status (low = ready)
//               FT_RDn, FT_WR            - read strobe (low), write strobe (high)
//               FT_DATA_In/Out, _OE      - split bidirectional data bus
//               rx_data/valid/ready      - received byte stream
//               tx_data/valid/ready      - transmit byte stream
//               busy                     - FSM not idle
// Revision    : 1.0 - initial release
// ============================================================================
module ft245_bus_ctrl
   import ft245_pkg::*;
#(
   parameter int SYNC_STAGES = 2,
   parameter int RD_PULSE    = 3,
   parameter int WR_PULSE    = 2,
   parameter int TURNAROUND  = 1
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       FT_RXFn,
   input  logic       FT_TXEn,
   output logic       FT_RDn,
   output logic       FT_WR,
   input  logic [7:0] FT_DATA_In,
   output logic [7:0] FT_DATA_Out,
   output logic       FT_DATA_OE,
   output logic [7:0] rx_data,
   output logic       rx_valid,
   input  logic       rx_ready,
   input  logic [7:0] tx_data,
   input  logic       tx_valid,
   output logic       tx_ready,
   output logic       busy
);

   localparam logic [CNT_W-1:0] C_RD_LOAD   = cnt_init(RD_PULSE);
   localparam logic [CNT_W-1:0] C_WR_LOAD   = cnt_init(WR_PULSE);
   // HOLD covers the synchronizer depth so status sampled during the
   // transfer has flushed out before the next arbitration decision.
   localparam logic [CNT_W-1:0] C_HOLD_LOAD = cnt_init(SYNC_STAGES + TURNAROUND);
   localparam logic [CNT_W-1:0] C_ONE       = cnt_init(1);

   state_t           r_state;
   grant_t           r_last_grant;
   logic [CNT_W-1:0] r_cnt;
   logic             r_rdn;
   logic             r_wr;
   logic             r_oe;
   logic [7:0]       r_dout;
   logic [7:0]       r_rx_data;
   logic             r_rx_valid;

   logic w_rxf_s;
   logic w_txe_s;
   logic w_rd_req;
   logic w_wr_req;
   logic w_idle;
   logic w_grant_rd;
   logic w_grant_wr;

   ft_sync #(.STAGES(SYNC_STAGES)) u_sync_rxf (
      .clk     (clk),
      .rst     (rst),
      .i_async (FT_RXFn),
      .o_sync  (w_rxf_s)
   );

   ft_sync #(.STAGES(SYNC_STAGES)) u_sync_txe (
      .clk     (clk),
      .rst     (rst),
      .i_async (FT_TXEn),
      .o_sync  (w_txe_s)
   );

   // A held, unconsumed RX byte blocks further reads but not writes.
   assign w_rd_req = !w_rxf_s && !r_rx_valid;
   assign w_wr_req = !w_txe_s && tx_valid;
   assign w_idle   = (r_state == IDLE);

   // Round robin: when both requesters are active, the one not served last wins.
   assign w_grant_rd = w_idle && w_rd_req && (!w_wr_req || (r_last_grant == GRANT_WRITE));
   assign w_grant_wr = w_idle && w_wr_req && (!w_rd_req || (r_last_grant == GRANT_READ));

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state      <= IDLE;
         r_last_grant <= GRANT_WRITE;
         r_cnt        <= C_ONE;
         r_rdn        <= 1'b1;
         r_wr         <= 1'b0;
         r_oe         <= 1'b0;
         r_dout       <= 8'h00;
         r_rx_data    <= 8'h00;
         r_rx_valid   <= 1'b0;
      end else begin
         // Consumer handshake; a capture later in this block takes priority.
         if (r_rx_valid && rx_ready) begin
            r_rx_valid <= 1'b0;
         end

         case (r_state)
            IDLE: begin
               if (w_grant_rd) begin
                  r_state      <= RD_STROBE;
                  r_rdn        <= 1'b0;
                  r_cnt        <= C_RD_LOAD;
                  r_last_grant <= GRANT_READ;
               end else if (w_grant_wr) begin
                  r_state      <= WR_SETUP;
                  r_oe         <= 1'b1;
                  r_dout       <= tx_data;
                  r_last_grant <= GRANT_WRITE;
               end
            end

            RD_STROBE: begin
               if (r_cnt == C_ONE) begin
                  // Data has been valid for the whole low pulse; sample it on
                  // the same edge that releases RD#.
                  r_rdn      <= 1'b1;
                  r_rx_data  <= FT_DATA_In;
                  r_rx_valid <= 1'b1;
                  r_state    <= HOLD;
                  r_cnt      <= C_HOLD_LOAD;
               end else begin
                  r_cnt <= r_cnt - C_ONE;
               end
            end

            WR_SETUP: begin
               r_wr    <= 1'b1;
               r_cnt   <= C_WR_LOAD;
               r_state <= WR_STROBE;
            end

            WR_STROBE: begin
               if (r_cnt == C_ONE) begin
                  // Data and OE stay asserted through the first HOLD cycle so
                  // the chip sees stable data across the WR falling edge.
                  r_wr    <= 1'b0;
                  r_state <= HOLD;
                  r_cnt   <= C_HOLD_LOAD;
               end else begin
                  r_cnt <= r_cnt - C_ONE;
               end
            end

            HOLD: begin
               r_oe <= 1'b0;
               if (r_cnt == C_ONE) begin
                  r_state <= IDLE;
               end else begin
                  r_cnt <= r_cnt - C_ONE;
               end
            end

            default: begin
               r_state <= IDLE;
               r_rdn   <= 1'b1;
               r_wr    <= 1'b0;
               r_oe    <= 1'b0;
            end
         endcase
      end
   end

   assign FT_RDn      = r_rdn;
   assign FT_WR       = r_wr;
   assign FT_DATA_OE  = r_oe;
   assign FT_DATA_Out = r_dout;
   assign rx_data     = r_rx_data;
   assign rx_valid    = r_rx_valid;
   // Gated by rst so the handshake cannot fire while the FSM is being reset.
   assign tx_ready    = w_grant_wr && !rst;
   assign busy        = !w_idle;

endmodule
`default_nettype wire
